// File: rtl/rom_loader.sv
// Streaming program loader: finds a sync byte, parses a big-endian address/length
// header, writes the payload to program memory and verifies an 8-bit zero-sum checksum.
module rom_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE, SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA, CSUM
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] addr;
  logic [15:0] count;
  logic [7:0]  csum;
  logic [7:0]  csum_nx;
  logic        accept;
  logic        launch;
  logic        cancel;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  always_comb begin
    in_ready = (state != IDLE);
    // abort suppresses consumption of whatever byte is on the bus that cycle
    accept   = in_ready && in_valid && !abort;
    launch   = (state == IDLE) && start && !abort;
    cancel   = (state != IDLE) && abort;
    csum_nx  = csum_add(csum, in_data);
    state_nx = state;
    case (state)
      IDLE:    if (launch) state_nx = SYNC;
      SYNC:    if (accept && in_data == SYNC_BYTE) state_nx = ADDR_H;
      ADDR_H:  if (accept) state_nx = ADDR_L;
      ADDR_L:  if (accept) state_nx = LEN_H;
      LEN_H:   if (accept) state_nx = LEN_L;
      LEN_L:   if (accept) state_nx = ({count[15:8], in_data} == 16'h0000) ? CSUM : DATA;
      DATA:    if (accept && count == 16'h0001) state_nx = CSUM;
      CSUM:    if (accept) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (cancel) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      addr      <= 16'h0000;
      count     <= 16'h0000;
      csum      <= 8'h00;
    end else begin
      mem_we <= 1'b0;
      if (launch) begin
        busy  <= 1'b1;
        done  <= 1'b0;
        error <= 1'b0;
        addr  <= 16'h0000;
        count <= 16'h0000;
        csum  <= 8'h00;
      end else if (cancel) begin
        busy  <= 1'b0;
        done  <= 1'b0;
        error <= 1'b1;
      end else if (accept) begin
        case (state)
          ADDR_H: begin addr[15:8]  <= in_data; csum <= csum_nx; end
          ADDR_L: begin addr[7:0]   <= in_data; csum <= csum_nx; end
          LEN_H:  begin count[15:8] <= in_data; csum <= csum_nx; end
          LEN_L:  begin count[7:0]  <= in_data; csum <= csum_nx; end
          DATA: begin
            // write stage: strobe lands one cycle after the byte is taken
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= in_data;
            addr      <= addr + 16'h0001;
            count     <= count - 16'h0001;
            csum      <= csum_nx;
          end
          CSUM: begin
            csum  <= csum_nx;
            busy  <= 1'b0;
            done  <= (csum_nx == 8'h00);
            error <= (csum_nx != 8'h00);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: expected memory writes go into a scoreboard queue
// that an independent monitor drains; status flags are checked after each frame.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  frame[$];

  rom_loader #(.SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("write_addr", {16'h0, mem_addr}, {16'h0, e[23:8]});
        chk("write_data", {24'h0, mem_wdata}, {24'h0, e[7:0]});
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic go;
    int   tries;
    bit   fin;
    tries = 0;
    fin   = 0;
    while (!fin) begin
      @(negedge clk);
      in_data  = b;
      in_valid = (tries >= 6) || ($urandom_range(0, 3) != 0);
      go       = in_valid && in_ready;
      @(posedge clk);
      #1 in_valid = 1'b0;
      tries++;
      if (go) fin = 1;
      else if (tries > 40) begin
        chk("byte_accept_timeout", 32'h0, 32'h1);
        fin = 1;
      end
    end
  endtask

  task automatic start_load();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", {31'h0, busy}, 32'h1);
    chk("start_flags", {30'h0, done, error}, 32'h0);
    chk("start_ready", {31'h0, in_ready}, 32'h1);
  endtask

  task automatic send_frame();
    foreach (frame[i]) send_byte(frame[i]);
    wait_cycles(2);
    chk("writes_drained", exp_q.size(), 32'h0);
  endtask

  task automatic chk_flags(input string name, input logic b, input logic d, input logic e);
    chk(name, {29'h0, busy, done, error}, {29'h0, b, d, e});
  endtask

  task automatic chk_reset_state();
    chk("rst_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    chk("rst_addr", {16'h0, mem_addr}, 32'h0);
    chk("rst_wdata", {24'h0, mem_wdata}, 32'h0);
    chk_flags("rst_flags", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    wait_cycles(3);
    chk_reset_state();
    rst_n = 1'b1;
    wait_cycles(2);

    // Good frame: sum 10+00+00+03+11+22+33 = 79, checksum 87 brings it to 00.
    start_load();
    exp_q.push_back(24'h1000_11);
    exp_q.push_back(24'h1001_22);
    exp_q.push_back(24'h1002_33);
    frame = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
    send_frame();
    chk_flags("good_flags", 1'b0, 1'b1, 1'b0);
    chk("hold_addr", {16'h0, mem_addr}, 32'h1002);
    chk("hold_wdata", {24'h0, mem_wdata}, 32'h33);

    // Same frame, bad checksum.
    start_load();
    exp_q.push_back(24'h1000_11);
    exp_q.push_back(24'h1001_22);
    exp_q.push_back(24'h1002_33);
    frame = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h7B};
    send_frame();
    chk_flags("bad_flags", 1'b0, 1'b0, 1'b1);

    // Leading junk discarded, address wraps FFFF -> 0000; sum FF+FF+00+02+AA+BB = 65, checksum 9B.
    start_load();
    exp_q.push_back(24'hFFFF_AA);
    exp_q.push_back(24'h0000_BB);
    frame = '{8'h00, 8'hFF, 8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hBB, 8'h9B};
    send_frame();
    chk_flags("wrap_flags", 1'b0, 1'b1, 1'b0);
    chk("wrap_hold_addr", {16'h0, mem_addr}, 32'h0000);

    // Abort after the second payload byte; the pending second write still lands.
    start_load();
    exp_q.push_back(24'h1000_11);
    exp_q.push_back(24'h1001_22);
    frame = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22};
    foreach (frame[i]) send_byte(frame[i]);
    @(negedge clk);
    in_data  = 8'h33;
    in_valid = 1'b1;
    abort    = 1'b1;
    @(posedge clk);
    #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    wait_cycles(3);
    chk("abort_writes", exp_q.size(), 32'h0);
    chk_flags("abort_flags", 1'b0, 1'b0, 1'b1);
    chk("abort_ready", {31'h0, in_ready}, 32'h0);

    // start and abort together in IDLE: nothing changes.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    wait_cycles(1);
    chk_flags("idle_abort_flags", 1'b0, 1'b0, 1'b1);
    chk("idle_abort_ready", {31'h0, in_ready}, 32'h0);

    // Zero-length frame: 12+34 = 46, checksum BA.
    start_load();
    frame = '{8'hA5, 8'h12, 8'h34, 8'h00, 8'h00, 8'hBA};
    send_frame();
    chk_flags("len0_flags", 1'b0, 1'b1, 1'b0);

    // Reset in the middle of DATA, with start held during reset.
    start_load();
    exp_q.push_back(24'h1000_11);
    frame = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h03, 8'h11};
    foreach (frame[i]) send_byte(frame[i]);
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    wait_cycles(2);
    start = 1'b0;
    chk_reset_state();
    chk("rst_pending", exp_q.size(), 32'h0);
    rst_n = 1'b1;
    wait_cycles(3);
    chk_flags("post_rst_idle", 1'b0, 1'b0, 1'b0);

    start_load();
    exp_q.push_back(24'h1000_11);
    exp_q.push_back(24'h1001_22);
    exp_q.push_back(24'h1002_33);
    frame = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
    send_frame();
    chk_flags("post_rst_flags", 1'b0, 1'b1, 1'b0);

    wait_cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
